// File: rtl/result_averager_if.sv
// result_averager_if: sample stream in, block statistics out.
//   InData   - signed 16-bit sample from the upstream stage
//   InValid  - InData is to be accepted this cycle
//   Clear    - synchronous restart of the current block
//   OutData  - signed block average (floor)
//   OutMin   - signed block minimum
//   OutMax   - signed block maximum
//   OutValid - one-cycle strobe: OutData/OutMin/OutMax are new
// master = sample producer / result consumer, slave = averager.
interface result_averager_if;
   logic signed [15:0] InData;
   logic               InValid;
   logic               Clear;
   logic signed [15:0] OutData;
   logic signed [15:0] OutMin;
   logic signed [15:0] OutMax;
   logic               OutValid;

   modport master (
      output InData, InValid, Clear,
      input  OutData, OutMin, OutMax, OutValid
   );

   modport slave (
      input  InData, InValid, Clear,
      output OutData, OutMin, OutMax, OutValid
   );
endinterface

// File: rtl/result_averager.sv
// result_averager: averages blocks of N = 2**LOG2_N signed samples and
// reports the floor average, minimum and maximum of each block.
//   Clk   - single clock, rising edge
//   Reset - asynchronous, active-high
//   bus   - result_averager_if.slave (InData/InValid/Clear in,
//           OutData/OutMin/OutMax/OutValid out, all outputs registered)
module result_averager #(
   parameter int unsigned LOG2_N = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   result_averager_if.slave      bus
);

   localparam int unsigned N  = 1 << LOG2_N;
   localparam int unsigned AW = 16 + LOG2_N;
   localparam int unsigned CW = (LOG2_N > 0) ? LOG2_N : 1;

   logic [CW-1:0]        count;
   logic signed [AW-1:0] acc;
   logic signed [15:0]   run_min;
   logic signed [15:0]   run_max;

   logic signed [AW-1:0] samp_ext;
   logic signed [AW-1:0] sum_c;
   logic signed [AW-1:0] avg_c;
   logic signed [15:0]   min_c;
   logic signed [15:0]   max_c;
   logic                 first_c;
   logic                 last_c;

   // Block statistics including the sample presented this cycle; the first
   // sample of a block seeds sum/min/max so nothing carries over.
   always_comb begin
      samp_ext = AW'(bus.InData);
      first_c  = (count == '0);
      last_c   = (count == CW'(N - 1));
      sum_c    = first_c ? samp_ext : (acc + samp_ext);
      min_c    = (first_c || (bus.InData < run_min)) ? bus.InData : run_min;
      max_c    = (first_c || (bus.InData > run_max)) ? bus.InData : run_max;
      // Arithmetic shift floors toward minus infinity; result always fits 16 bits.
      avg_c    = sum_c >>> LOG2_N;
   end

   // Accumulation and registered block outputs; Clear beats InValid.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count        <= '0;
         acc          <= '0;
         run_min      <= '0;
         run_max      <= '0;
         bus.OutData  <= '0;
         bus.OutMin   <= '0;
         bus.OutMax   <= '0;
         bus.OutValid <= 1'b0;
      end else begin
         bus.OutValid <= 1'b0;
         if (bus.Clear) begin
            count <= '0;
            acc   <= '0;
         end else if (bus.InValid) begin
            if (last_c) begin
               // Block complete: publish and restart with no gap cycle.
               count        <= '0;
               acc          <= '0;
               bus.OutData  <= 16'(avg_c);
               bus.OutMin   <= min_c;
               bus.OutMax   <= max_c;
               bus.OutValid <= 1'b1;
            end else begin
               count <= count + CW'(1);
               acc   <= sum_c;
            end
            run_min <= min_c;
            run_max <= max_c;
         end
      end
   end

endmodule
